// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared state encodings, control bundle and defaults for the pipeline sequencer
package hazard_ctrl_pkg;
  localparam int MEM_TIMEOUT_DEF = 16;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic pipe_hold;
    logic memwb_flush;
  } ctrl_t;
  localparam ctrl_t CTRL_RUN    = 7'b1100000;
  localparam ctrl_t CTRL_HOLD   = 7'b0000011;
  localparam ctrl_t CTRL_SQUASH = 7'b1111100;
  localparam ctrl_t CTRL_STALL  = 7'b0001000;
endpackage

// File: rtl/hazard_ctrl_detect.sv
// hazard_detect: combinational load-use and taken-branch decode
module hazard_detect (
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic [4:0] idex_rt,
  input  logic       idex_memread,
  input  logic       exmem_branch,
  input  logic       exmem_zero,
  output logic       lu_haz,
  output logic       br_taken
);
  assign br_taken = exmem_branch & exmem_zero;
  assign lu_haz = idex_memread & (idex_rt != 5'd0) & ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for load-use stalls, branch squashes and memory waits
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IFID_RS,
  input  logic [4:0]       IFID_RT,
  input  logic [4:0]       IDEX_RT,
  input  logic             IDEX_MemRead,
  input  logic             EXMEM_Branch,
  input  logic             EXMEM_Zero,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             EXMEM_Flush,
  output logic             pipe_hold,
  output logic             MEMWB_Flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count
);
  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  state_t state;
  ctrl_t ctrl;
  logic [WC_W-1:0] wait_cnt;
  logic lu_haz, br_taken, mwait, timeout, hold, lu_stall;
  hazard_detect u_detect (
    .ifid_rs(IFID_RS),
    .ifid_rt(IFID_RT),
    .idex_rt(IDEX_RT),
    .idex_memread(IDEX_MemRead),
    .exmem_branch(EXMEM_Branch),
    .exmem_zero(EXMEM_Zero),
    .lu_haz(lu_haz),
    .br_taken(br_taken)
  );
  assign mwait = mem_req & ~mem_ready;
  assign timeout = (state == ST_MEM_WAIT) && mwait && (wait_cnt == WC_W'(MEM_TIMEOUT));
  assign hold = mwait & ~timeout;
  assign lu_stall = lu_haz && (state == ST_RUN) && !mwait && !br_taken;
  // Mealy control decode; a timed-out access releases with plain defaults
  always_comb
    ctrl = !reset ? CTRL_RUN :
           hold ? CTRL_HOLD :
           (br_taken && !timeout) ? CTRL_SQUASH :
           lu_stall ? CTRL_STALL : CTRL_RUN;
  assign {PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, pipe_hold, MEMWB_Flush} = ctrl;
  // sequencer state, wait timer, sticky error and saturating stall statistic
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_RUN;
      wait_cnt <= '0;
      mem_err <= 1'b0;
      stall_count <= '0;
    end else begin
      state <= hold ? ST_MEM_WAIT : lu_stall ? ST_LU_STALL : ST_RUN;
      wait_cnt <= !hold ? '0 : (state == ST_MEM_WAIT) ? wait_cnt + WC_W'(1) : WC_W'(1);
      mem_err <= mem_err | timeout;
      if (!ctrl.pc_write && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
    end
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage MIPS datapath.
- Drives write-enable, hold and flush controls into the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB buffers.
- Handles three conditions: load-use stalls, taken-branch squashes (branch resolved in MEM), and variable-latency data-memory waits with a timeout.
- Sits beside the buffers in the CPU top level.

Parameters:
- MEM_TIMEOUT, 16, maximum cycles spent in MEM_WAIT before mem_err is raised.
- CNT_W, 16, width of the stall_count statistic counter.

Ports:
- clk  in  1  system clock; state updates on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- IFID_RS  in  5  rs field of the instruction in ID.
- IFID_RT  in  5  rt field of the instruction in ID.
- IDEX_RT  in  5  RT_out of the ID/EX buffer.
- IDEX_MemRead  in  1  MemRead_out of the ID/EX buffer.
- EXMEM_Branch  in  1  Branch flag in the MEM stage.
- EXMEM_Zero  in  1  ALU zero flag in the MEM stage.
- mem_req  in  1  MemRead or MemWrite active in the MEM stage.
- mem_ready  in  1  data memory completes this cycle.
- PCWrite  out  1  PC load enable.
- IFID_Write  out  1  IF/ID load enable.
- IFID_Flush  out  1  zero IF/ID on the next capture.
- IDEX_Flush  out  1  load a bubble (all controls 0) into ID/EX.
- EXMEM_Flush  out  1  load a bubble into EX/MEM.
- pipe_hold  out  1  freeze ID/EX and EX/MEM.
- MEMWB_Flush  out  1  load a bubble into MEM/WB.
- mem_err  out  1  sticky memory-timeout error.
- stall_count  out  CNT_W  saturating count of cycles with PCWrite=0.

Behaviour:
- States: RUN, LU_STALL, MEM_WAIT. Encoding comes from the shared header.
- Control outputs are a combinational (Mealy) function of the registered state and current inputs.
- Default outputs: PCWrite=1, IFID_Write=1, all flushes/holds 0.
- Derived terms:
  - br_taken = EXMEM_Branch & EXMEM_Zero.
  - lu_haz = IDEX_MemRead & (IDEX_RT!=0) & (IDEX_RT==IFID_RS | IDEX_RT==IFID_RT).
  - mwait = mem_req & ~mem_ready.
- Priority, highest first: reset > mwait > br_taken > lu_haz.
- RUN:
  - mwait: PCWrite=0, IFID_Write=0, pipe_hold=1, MEMWB_Flush=1; next state MEM_WAIT; wait_cnt<=1.
  - else br_taken: IFID_Flush=1, IDEX_Flush=1, EXMEM_Flush=1, PCWrite=1 (target loaded); stay in RUN. Any lu_haz in that cycle is ignored.
  - else lu_haz: PCWrite=0, IFID_Write=0, IDEX_Flush=1; next state LU_STALL.
- LU_STALL:
  - lu_haz detection suppressed; default outputs; next state RUN.
  - mwait and br_taken are still honoured exactly as in RUN.
  - Exactly one bubble per load-use.
- MEM_WAIT:
  - While mwait holds: same hold outputs as on entry; wait_cnt increments.
  - mem_ready=1: default outputs this cycle; next state RUN. A br_taken present this cycle is applied.
  - wait_cnt==MEM_TIMEOUT with mem_ready still 0: mem_err<=1; next state RUN; default outputs. The stalled access is abandoned.
- mem_err: sticky; cleared only by reset.
- stall_count: +1 on every posedge where PCWrite==0; saturates at all-ones, no wrap.
- Reset (reset==0 at posedge): state=RUN, wait_cnt=0, mem_err=0, stall_count=0. While reset is low, outputs are forced to the default values (PCWrite=1, IFID_Write=1, flushes/holds 0). Reset mid-MEM_WAIT or mid-LU_STALL aborts to RUN with no residual hold.
- Register 0 never causes a load-use stall.

Decomposition:
- definitions.vh gains the state encodings (ST_RUN, ST_LU_STALL, ST_MEM_WAIT) and the MEM_TIMEOUT default.
- One natural sub-module: hazard_detect, a combinational lu_haz/br_taken decode, instantiated inside hazard_ctrl.

Test Plan:
1. Load-use: IDEX_MemRead=1, IDEX_RT=5, IFID_RS=5 in RUN -> that cycle PCWrite=0, IFID_Write=0, IDEX_Flush=1; next cycle state LU_STALL with default outputs; stall_count=1.
2. Load-use to $0: IDEX_MemRead=1, IDEX_RT=0, IFID_RT=0 -> no stall, outputs default, stall_count stays 0.
3. Branch over hazard: EXMEM_Branch=1, EXMEM_Zero=1, plus lu_haz true -> IFID/IDEX/EXMEM_Flush=1, PCWrite=1, no LU_STALL entry.
4. Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> pipe_hold=1 and MEMWB_Flush=1 for 3 cycles, release on the 4th; stall_count=3; mem_err=0.
5. Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> mem_err rises after the 4th wait cycle, state returns to RUN; mem_err stays 1 until reset=0.
6. Reset mid-wait: reset=0 during MEM_WAIT -> next posedge: state RUN, pipe_hold=0, stall_count=0, mem_err=0; stall_count saturation checked separately with CNT_W=4 (stays 15).
